// File: rtl/store_pkg.sv
// Shared types and constants for the in-order store commit queue.
// The entry struct fixes the tag and address/data widths for the whole slice.
package store_pkg;

  localparam int unsigned SQ_XLEN  = 32;
  localparam int unsigned SQ_TAG_W = 6;
  localparam int unsigned STRB_W   = SQ_XLEN / 8;

  localparam logic [2:0] WIDTH_SB = 3'b000;
  localparam logic [2:0] WIDTH_SH = 3'b001;
  localparam logic [2:0] WIDTH_SW = 3'b010;

  typedef struct packed {
    logic [2:0]          width;
    logic [SQ_TAG_W-1:0] tag;
    logic [SQ_XLEN-1:0]  addr;
    logic [SQ_XLEN-1:0]  data;
  } sq_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane steering for one store: width and address offset
// select the write strobes and shift low-aligned data into its lanes.
module store_lane_align
  import store_pkg::*;
(
  input  logic [2:0]         width,
  input  logic [1:0]         off,
  input  logic [SQ_XLEN-1:0] data,
  output logic [STRB_W-1:0]  wstrb,
  output logic [SQ_XLEN-1:0] wdata,
  output logic               misalign
);

  always_comb begin
    wstrb    = '0;
    wdata    = data;
    misalign = 1'b0;
    case (width)
      WIDTH_SB: begin
        wstrb = STRB_W'(1) << off;
        wdata = data << {off, 3'b000};
      end
      WIDTH_SH: begin
        if (off[0]) begin
          misalign = 1'b1;
        end else begin
          wstrb = STRB_W'(3) << {off[1], 1'b0};
          wdata = data << {off[1], 4'b0000};
        end
      end
      WIDTH_SW: begin
        if (off != 2'b00) misalign = 1'b1;
        else              wstrb    = '1;
      end
      // Unknown widths still drain, with no lanes enabled.
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_commit_queue.sv
// In-order store queue: buffers executed stores, marks them committed as the ROB
// retires their tags, and drains committed stores to memory via valid/ready.
module store_commit_queue
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = SQ_TAG_W,
  parameter int unsigned XLEN  = SQ_XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_width,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [XLEN-1:0]          in_addr,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     commit_valid,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic                     flush,
  output logic                     mem_req,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [XLEN/8-1:0]        mem_wstrb,
  input  logic [XLEN-1:0]          ld_addr,
  output logic                     ld_conflict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry a wrap bit: [head,cmt) committed, [cmt,tail) awaiting retire.
  logic [PW-1:0] head_q, cmt_q, tail_q;
  logic [PW-1:0] head_d, cmt_d, tail_d;
  logic          err_q, err_d;
  sq_entry_t     entries_q [DEPTH];

  logic      full;
  logic      enq;
  logic      cmt_ok;
  logic      cmt_bad;
  logic      deq;
  logic      misalign;
  sq_entry_t head_e;
  logic      unused_ld_off;

  assign count    = tail_q - head_q;
  assign full     = count == PW'(DEPTH);
  assign in_ready = !full && !flush && !reset;
  assign enq      = in_valid && in_ready;

  assign cmt_ok  = commit_valid && (cmt_q != tail_q) &&
                   (commit_tag == entries_q[cmt_q[AW-1:0]].tag);
  assign cmt_bad = commit_valid && !cmt_ok;

  assign head_e  = entries_q[head_q[AW-1:0]];
  assign mem_req = head_q != cmt_q;
  assign deq     = mem_req && mem_ready;
  assign err     = err_q;

  assign mem_addr = {head_e.addr[XLEN-1:2], 2'b00};

  store_lane_align u_lane_align (
    .width    (head_e.width),
    .off      (head_e.addr[1:0]),
    .data     (head_e.data),
    .wstrb    (mem_wstrb),
    .wdata    (mem_wdata),
    .misalign (misalign)
  );

  always_comb begin
    head_d = head_q + (deq ? PW'(1) : PW'(0));
    cmt_d  = cmt_q + (cmt_ok ? PW'(1) : PW'(0));
    // A flush keeps only committed entries, including one retiring this cycle.
    tail_d = flush ? cmt_d : tail_q + (enq ? PW'(1) : PW'(0));
    err_d  = err_q || cmt_bad || (mem_req && misalign);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entries_q[tail_q[AW-1:0]] <= '{width: in_width, tag: in_tag,
                                     addr: in_addr, data: in_data};
    end
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] rel;
      rel = AW'(i) - head_q[AW-1:0];
      if (({1'b0, rel} < count) &&
          (entries_q[i].addr[XLEN-1:2] == ld_addr[XLEN-1:2])) begin
        ld_conflict = 1'b1;
      end
    end
  end

  assign unused_ld_off = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_store_commit_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_width;
  logic [5:0]  in_tag;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        commit_valid;
  logic [5:0]  commit_tag;
  logic        flush;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic [3:0]  count;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  store_commit_queue dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_width     (in_width),
    .in_tag       (in_tag),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .commit_valid (commit_valid),
    .commit_tag   (commit_tag),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .ld_addr      (ld_addr),
    .ld_conflict  (ld_conflict),
    .count        (count),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_set(input logic [2:0] w, input logic [5:0] t,
                         input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_width = w;
    in_tag   = t;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic commit_set(input logic [5:0] t);
    commit_valid = 1'b1;
    commit_tag   = t;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_width = 3'b010; in_tag = '0; in_addr = '0;
    in_data = '0; commit_valid = 1'b0; commit_tag = '0; flush = 1'b0;
    mem_ready = 1'b0; ld_addr = 32'h0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 1: single SW store round trip
    enq_set(3'b010, 6'd5, 32'h100, 32'hDEADBEEF);
    tick();
    in_valid = 1'b0;
    check("t1_count", count, 1);
    check("t1_no_req_before_commit", mem_req, 0);
    commit_set(6'd5);
    tick();
    commit_valid = 1'b0;
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_strb", mem_wstrb, 4'b1111);
    check("t1_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("t1_count_empty", count, 0);
    check("t1_req_drop", mem_req, 0);

    // 2: SB and SH lane steering
    enq_set(3'b000, 6'd1, 32'h203, 32'h000000AB);
    tick();
    enq_set(3'b001, 6'd2, 32'h202, 32'h00001234);
    tick();
    in_valid = 1'b0;
    commit_set(6'd1);
    tick();
    commit_set(6'd2);
    tick();
    commit_valid = 1'b0;
    check("t2_sb_addr", mem_addr, 32'h200);
    check("t2_sb_strb", mem_wstrb, 4'b1000);
    check("t2_sb_wdata", mem_wdata, 32'hAB000000);
    mem_ready = 1'b1;
    tick();
    check("t2_sh_strb", mem_wstrb, 4'b1100);
    check("t2_sh_wdata", mem_wdata, 32'h12340000);
    tick();
    mem_ready = 1'b0;
    check("t2_count_empty", count, 0);
    check("t2_err_clear", err, 0);

    // 3: fill to full across the pointer wrap, no enqueue bypass on drain
    for (int k = 0; k < 8; k++) begin
      enq_set(3'b010, 6'(k), 32'h1000 + 32'(4 * k), 32'(k));
      tick();
    end
    enq_set(3'b010, 6'd9, 32'h9000, 32'h9);
    #1;
    check("t3_full_in_ready", in_ready, 0);
    check("t3_full_count", count, 8);
    tick();
    check("t3_full_hold_count", count, 8);
    in_valid = 1'b0;
    commit_set(6'd0);
    tick();
    commit_valid = 1'b0;
    enq_set(3'b010, 6'd8, 32'h1020, 32'h8);
    mem_ready = 1'b1;
    #1;
    check("t3_no_bypass_ready", in_ready, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    check("t3_after_drain_count", count, 7);
    check("t3_after_drain_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t3_refill_count", count, 8);
    for (int k = 1; k <= 8; k++) begin
      commit_set(6'(k));
      tick();
    end
    commit_valid = 1'b0;
    check("t3_all_committed_err", err, 0);
    mem_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t3_drain_addr_%0d", k), mem_addr, 32'h1000 + 32'(4 * k));
      check($sformatf("t3_drain_data_%0d", k), mem_wdata, 32'(k));
      tick();
    end
    mem_ready = 1'b0;
    check("t3_empty", count, 0);

    // 4: flush in the cycle tag 12 retires keeps entries 10..12 only
    for (int k = 0; k < 4; k++) begin
      enq_set(3'b010, 6'(10 + k), 32'h2000 + 32'(4 * k), 32'hA0 + 32'(k));
      tick();
    end
    in_valid = 1'b0;
    commit_set(6'd10);
    tick();
    commit_set(6'd11);
    tick();
    commit_set(6'd12);
    flush = 1'b1;
    #1;
    check("t4_flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    commit_valid = 1'b0;
    check("t4_count_after_flush", count, 3);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t4_req_%0d", k), mem_req, 1);
      check($sformatf("t4_addr_%0d", k), mem_addr, 32'h2000 + 32'(4 * k));
      tick();
    end
    mem_ready = 1'b0;
    check("t4_flushed_not_drained", mem_req, 0);
    check("t4_empty", count, 0);

    // 5: wrong commit tag is sticky and leaves cmt alone
    enq_set(3'b010, 6'd4, 32'h3000, 32'h44);
    tick();
    in_valid = 1'b0;
    commit_set(6'd9);
    tick();
    commit_valid = 1'b0;
    check("t5_err_set", err, 1);
    check("t5_cmt_unchanged", mem_req, 0);
    commit_set(6'd4);
    tick();
    commit_valid = 1'b0;
    check("t5_late_commit_req", mem_req, 1);
    check("t5_err_sticky", err, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_err_cleared", err, 0);
    enq_set(3'b001, 6'd3, 32'h101, 32'h5555);
    tick();
    in_valid = 1'b0;
    commit_set(6'd3);
    tick();
    commit_valid = 1'b0;
    check("t5_misalign_req", mem_req, 1);
    check("t5_misalign_strb", mem_wstrb, 4'b0000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("t5_misalign_err", err, 1);
    check("t5_misalign_drained", count, 0);

    // 6: backpressure holds outputs; load conflict; reset mid-drain
    reset = 1'b1;
    tick();
    reset = 1'b0;
    enq_set(3'b010, 6'd7, 32'h104, 32'h55AA);
    tick();
    in_valid = 1'b0;
    ld_addr = 32'h106;
    #1;
    check("t6_ld_conflict_hit", ld_conflict, 1);
    ld_addr = 32'h108;
    #1;
    check("t6_ld_conflict_miss", ld_conflict, 0);
    commit_set(6'd7);
    tick();
    commit_set(6'd60);
    for (int k = 0; k < 5; k++) begin
      tick();
      commit_valid = 1'b0;
      check($sformatf("t6_hold_req_%0d", k), mem_req, 1);
      check($sformatf("t6_hold_addr_%0d", k), mem_addr, 32'h104);
      check($sformatf("t6_hold_data_%0d", k), mem_wdata, 32'h55AA);
    end
    check("t6_err_before_reset", err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ld_addr = 32'h106;
    #1;
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_ld_conflict", ld_conflict, 0);

    // 7: enqueue, commit and drain in one cycle
    enq_set(3'b010, 6'd1, 32'h500, 32'h1);
    tick();
    enq_set(3'b010, 6'd2, 32'h504, 32'h2);
    commit_set(6'd1);
    tick();
    check("t7_count_two", count, 2);
    enq_set(3'b010, 6'd3, 32'h508, 32'h3);
    commit_set(6'd2);
    mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    commit_valid = 1'b0;
    mem_ready = 1'b0;
    check("t7_count_steady", count, 2);
    check("t7_req", mem_req, 1);
    check("t7_head_addr", mem_addr, 32'h504);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
